// File: rtl/clock_switch_ctrl_m.sv
// clock_switch_ctrl_m: sequences speed changes of the CPU clock divider.
// A request waits for a CPU cycle boundary, then the CPU is held, the divider
// phase is reset, the new mode is applied and the clock is allowed to settle
// before the CPU is released.
// Optional feature: define CLKSW_TIMEOUT_EN to add a WAIT-state watchdog that
// aborts a request when no cycle boundary arrives within TIMEOUT_CYCLES.
module clock_switch_ctrl_m #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] req_mode,
  output logic       req_ready,
  input  logic       cycle_end,
  output logic       cpu_hold,
  output logic       divider_en,
  output logic       div4not2,
  output logic       div_resetb,
  output logic [1:0] mode_q,
  output logic       switch_done,
  output logic       req_err
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    APPLY,
    SETTLE,
    DONE
  } state_t;

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_DIV4   = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  // Reject out-of-range configurations at elaboration time.
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("clock_switch_ctrl_m: SETTLE_CYCLES or TIMEOUT_CYCLES out of range");
  end

  state_t     state, state_n;
  logic [1:0] mode_req, mode_req_n;
  logic [7:0] count, count_n;
  logic       req_ready_n, cpu_hold_n, divider_en_n, div4not2_n, div_resetb_n;
  logic [1:0] mode_q_n;
  logic       switch_done_n, req_err_n;
  logic       accept;

`ifdef CLKSW_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LOAD = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wdog, wdog_n;
`endif

  assign accept = req_valid & req_ready;

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_n       = state;
    mode_req_n    = mode_req;
    count_n       = count;
    cpu_hold_n    = cpu_hold;
    divider_en_n  = divider_en;
    div4not2_n    = div4not2;
    div_resetb_n  = div_resetb;
    mode_q_n      = mode_q;
    switch_done_n = 1'b0;
    req_err_n     = 1'b0;
`ifdef CLKSW_TIMEOUT_EN
    wdog_n        = wdog;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          mode_req_n = req_mode;
          if (req_mode == MODE_RSVD) begin
            req_err_n = 1'b1;
          end else if (req_mode == mode_q) begin
            // Already running in the requested mode: report completion only.
            state_n       = DONE;
            switch_done_n = 1'b1;
          end else begin
            state_n = WAIT;
`ifdef CLKSW_TIMEOUT_EN
            wdog_n  = TIMEOUT_LOAD;
`endif
          end
        end
      end
      WAIT: begin
        // A boundary arriving on the expiry cycle still wins over the abort.
        if (cycle_end) begin
          state_n      = APPLY;
          cpu_hold_n   = 1'b1;
          div_resetb_n = 1'b0;
        end
`ifdef CLKSW_TIMEOUT_EN
        else if (wdog == 16'd0) begin
          state_n   = IDLE;
          req_err_n = 1'b1;
        end else begin
          wdog_n = wdog - 16'd1;
        end
`endif
      end
      APPLY: begin
        // Divider controls change only here, while the CPU is held.
        divider_en_n = (mode_req != MODE_BYPASS);
        div4not2_n   = (mode_req == MODE_DIV4);
        mode_q_n     = mode_req;
        div_resetb_n = 1'b1;
        count_n      = SETTLE_LOAD;
        state_n      = SETTLE;
      end
      SETTLE: begin
        if (count == 8'd0) begin
          state_n       = DONE;
          cpu_hold_n    = 1'b0;
          switch_done_n = 1'b1;
        end else begin
          count_n = count - 8'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    req_ready_n = (state_n == IDLE);
  end

  // State and registered-output update; reset returns everything to bypass.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mode_req    <= MODE_BYPASS;
      count       <= 8'd0;
      req_ready   <= 1'b1;
      cpu_hold    <= 1'b0;
      divider_en  <= 1'b0;
      div4not2    <= 1'b0;
      div_resetb  <= 1'b1;
      mode_q      <= MODE_BYPASS;
      switch_done <= 1'b0;
      req_err     <= 1'b0;
`ifdef CLKSW_TIMEOUT_EN
      wdog        <= 16'd0;
`endif
    end else begin
      // NOTE: non-blocking assignments so all registers update together from
      // values computed before the edge.
      state       <= state_n;
      mode_req    <= mode_req_n;
      count       <= count_n;
      req_ready   <= req_ready_n;
      cpu_hold    <= cpu_hold_n;
      divider_en  <= divider_en_n;
      div4not2    <= div4not2_n;
      div_resetb  <= div_resetb_n;
      mode_q      <= mode_q_n;
      switch_done <= switch_done_n;
      req_err     <= req_err_n;
`ifdef CLKSW_TIMEOUT_EN
      wdog        <= wdog_n;
`endif
    end
  end

endmodule

// File: tb/tb_clock_switch_ctrl_m.sv
// Testbench for clock_switch_ctrl_m: randomized requests with a scoreboard.
// The driver predicts each request's outcome (error, no-op completion or full
// switch with its hold length and completion cycle) and queues it; a monitor
// pops and compares whenever switch_done or req_err pulses.
`timescale 1ns/1ps
module tb_clock_switch_ctrl_m;

  localparam int S = 4;
  localparam int T = 8;
`ifdef CLKSW_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_mode = 2'b00;
  logic       cycle_end = 1'b0;
  logic       req_ready, cpu_hold, divider_en, div4not2, div_resetb;
  logic [1:0] mode_q;
  logic       switch_done, req_err;

  clock_switch_ctrl_m #(
    .SETTLE_CYCLES (S),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clkin      (clkin),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_mode   (req_mode),
    .req_ready  (req_ready),
    .cycle_end  (cycle_end),
    .cpu_hold   (cpu_hold),
    .divider_en (divider_en),
    .div4not2   (div4not2),
    .div_resetb (div_resetb),
    .mode_q     (mode_q),
    .switch_done(switch_done),
    .req_err    (req_err)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    bit         is_err;
    logic [1:0] mode;    // mode expected on mode_q at the event
    int         at_cyc;  // cycle count at which the event is visible
    int         hold;    // cpu_hold cycles since the previous event
    int         rstlow;  // div_resetb-low cycles since the previous event
  } exp_t;

  exp_t       q[$];
  logic [1:0] model_mode = 2'b00;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         hold_cnt = 0;
  int         rst_cnt = 0;
  exp_t       mon_e;

  always @(posedge clkin) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: counts hold/phase-reset cycles and scores every event.
  always @(negedge clkin) begin
    if (reset) begin
      hold_cnt = 0;
      rst_cnt  = 0;
    end else begin
      if (cpu_hold) hold_cnt++;
      if (!div_resetb) rst_cnt++;
      if (switch_done || req_err) begin
        if (q.size() == 0) begin
          check("unexpected_event", {switch_done, req_err}, 0);
        end else begin
          mon_e = q.pop_front();
          check("event_kind", {switch_done, req_err}, mon_e.is_err ? 2'b01 : 2'b10);
          check("event_cycle", cyc, mon_e.at_cyc);
          check("mode_q", mode_q, mon_e.mode);
          check("divider_en", divider_en, mon_e.mode != 2'b00);
          check("div4not2", div4not2, mon_e.mode == 2'b10);
          check("hold_cycles", hold_cnt, mon_e.hold);
          check("div_reset_cycles", rst_cnt, mon_e.rstlow);
          check("req_ready_at_event", req_ready, mon_e.is_err);
        end
        hold_cnt = 0;
        rst_cnt  = 0;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clkin); #1;
      n++;
    end
    check("ready_wait", req_ready, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clkin); #1;
      n++;
    end
    check("drain", q.size(), 0);
    q.delete();
  endtask

  // Issue one request; cycle_end is pulsed after d WAIT cycles for a switch.
  task automatic do_req(input logic [1:0] m, input int d, input bit extra);
    exp_t e;
    int   a;
    bit   real_switch;
    wait_ready();
    a = cyc + 1;
    real_switch = (m != 2'b11) && (m != model_mode);
    if (m == 2'b11)              e = '{1'b1, model_mode, a, 0, 0};
    else if (!real_switch)       e = '{1'b0, m, a, 0, 0};
    else if (TO_ON && d >= T)    e = '{1'b1, model_mode, a + T, 0, 0};
    else begin
      e = '{1'b0, m, a + d + 2 + S, S + 1, 1};
      model_mode = m;
    end
    q.push_back(e);
    req_valid = 1'b1;
    req_mode  = m;
    cycle_end = 1'($urandom);
    @(posedge clkin); #1;
    req_valid = 1'b0;
    cycle_end = 1'b0;
    if (real_switch) begin
      for (int i = 0; i < d; i++) begin
        if (extra && i == 0) begin
          req_valid = 1'b1;
          req_mode  = 2'($urandom);
        end
        @(posedge clkin); #1;
        req_valid = 1'b0;
      end
      cycle_end = 1'b1;
      @(posedge clkin); #1;
      cycle_end = 1'b0;
    end
    drain();
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [1:0] m;
    repeat (3) @(posedge clkin);
    @(negedge clkin) reset = 1'b0;
    @(posedge clkin); #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_divider_en", divider_en, 0);
    check("rst_div4not2", div4not2, 0);
    check("rst_div_resetb", div_resetb, 1);
    check("rst_mode_q", mode_q, 0);
    check("rst_switch_done", switch_done, 0);
    check("rst_req_err", req_err, 0);

    // Directed: bypass->div4, div4->div2, div2->bypass, no-op, reserved.
    do_req(2'b10, 2, 1'b0);
    do_req(2'b01, 3, 1'b0);
    do_req(2'b00, 1, 1'b0);
    do_req(2'b00, 0, 1'b0);
    do_req(2'b11, 0, 1'b0);
    check("mode_after_reserved", mode_q, 0);
    do_req(2'b10, 4, 1'b1);

    // Reset asserted during SETTLE.
    m = (model_mode == 2'b10) ? 2'b01 : 2'b10;
    wait_ready();
    req_valid = 1'b1;
    req_mode  = m;
    @(posedge clkin); #1;
    req_valid = 1'b0;
    cycle_end = 1'b1;
    @(posedge clkin); #1;
    cycle_end = 1'b0;
    @(posedge clkin); #1;
    check("pre_reset_hold", cpu_hold, 1);
    check("pre_reset_mode", mode_q, m);
    reset = 1'b1;
    #1;
    check("midrst_cpu_hold", cpu_hold, 0);
    check("midrst_divider_en", divider_en, 0);
    check("midrst_div4not2", div4not2, 0);
    check("midrst_mode_q", mode_q, 0);
    check("midrst_div_resetb", div_resetb, 1);
    check("midrst_req_ready", req_ready, 1);
    q.delete();
    model_mode = 2'b00;
    @(negedge clkin);
    @(negedge clkin) reset = 1'b0;
    do_req(2'b01, 2, 1'b0);

    if (TO_ON) begin
      m = (model_mode == 2'b10) ? 2'b01 : 2'b10;
      do_req(m, T, 1'b0);
      check("mode_after_timeout", mode_q, model_mode);
      do_req(m, T - 1, 1'b0);
    end

    // Randomized requests, including no-ops, reserved modes and stray valids.
    for (int i = 0; i < 40; i++) begin
      int d;
      d = $urandom_range(0, 11);
      do_req(2'($urandom_range(0, 3)), d, (d > 0) && ($urandom_range(0, 1) == 1));
    end

    repeat (5) @(posedge clkin);
    #1;
    check("final_queue_empty", q.size(), 0);
    check("final_mode_q", mode_q, model_mode);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
